// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: bundle of both master-side Wishbone ports and the shared
// downstream bus of wb_arbiter2.
// Modports: slave = the arbiter's view; master = the environment's view
// (both requesters plus the downstream interconnect).
interface wb_arbiter2_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
);
    // m0: CPU core
    logic [DATA_WIDTH-1:0]   m0_dat_i;
    logic [DATA_WIDTH-1:0]   m0_dat_o;
    logic [ADDR_WIDTH-1:0]   m0_adr_i;
    logic [DATA_WIDTH/8-1:0] m0_sel_i;
    logic                    m0_we_i;
    logic                    m0_cyc_i;
    logic                    m0_stb_i;
    logic                    m0_ack_o;
    logic                    m0_err_o;
    // m1: gdb target
    logic [DATA_WIDTH-1:0]   m1_dat_i;
    logic [DATA_WIDTH-1:0]   m1_dat_o;
    logic [ADDR_WIDTH-1:0]   m1_adr_i;
    logic [DATA_WIDTH/8-1:0] m1_sel_i;
    logic                    m1_we_i;
    logic                    m1_cyc_i;
    logic                    m1_stb_i;
    logic                    m1_ack_o;
    logic                    m1_err_o;
    // shared bus toward the interconnect
    logic [DATA_WIDTH-1:0]   s_dat_o;
    logic [ADDR_WIDTH-1:0]   s_adr_o;
    logic [DATA_WIDTH/8-1:0] s_sel_o;
    logic                    s_we_o;
    logic                    s_cyc_o;
    logic                    s_stb_o;
    logic [DATA_WIDTH-1:0]   s_dat_i;
    logic                    s_ack_i;

    modport slave (
        input  m0_dat_i, m0_adr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_dat_i, m1_adr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_dat_o, s_adr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output m0_dat_i, m0_adr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_dat_i, m1_adr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_dat_o, s_adr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone arbiter (m0 = CPU core, m1 = gdb target)
// onto one shared bus; round-robin on ties, grant locked for the whole cyc_i.
// Latency: 1 cycle from cyc_i in IDLE to s_cyc_o; bus mux, ack and read data
// are combinational. Backpressure: a master waits on its strobe until s_ack_i;
// with macro WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES stalled strobe cycles
// abort the cycle with a one-cycle err pulse.
// Ports: clk_i, rst_i (asynchronous, active-high), bus (wb_arbiter2_if.slave)
// carrying m0_*/m1_* master ports and the s_* shared-bus ports.
module wb_arbiter2 #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_arbiter2_if.slave bus
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_m1;    // 1: m1 was served last, so m0 wins the next tie
    logic   gnt0;
    logic   gnt1;
    logic   req0;
    logic   req1;
    logic   abort;

    logic [ADDR_WIDTH-1:0] s_adr;
    logic [DATA_WIDTH-1:0] s_dat;
    logic [SEL_WIDTH-1:0]  s_sel;
    logic                  s_we;
    logic                  s_cyc;
    logic                  s_stb;

    assign gnt0 = (state == GRANT0);
    assign gnt1 = (state == GRANT1);

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] stall_cnt;
    logic [1:0] blocked;
    logic       stalled;

    // A master that was aborted may not compete until it has let go of cyc_i.
    assign req0    = bus.m0_cyc_i & ~blocked[0];
    assign req1    = bus.m1_cyc_i & ~blocked[1];
    assign stalled = (gnt0 | gnt1) & s_stb & ~bus.s_ack_i;
    // An ack in the same cycle as the limit wins over the abort.
    assign abort   = (gnt0 | gnt1) & (stall_cnt == STALL_LIMIT) & ~bus.s_ack_i;
`else
    assign req0  = bus.m0_cyc_i;
    assign req1  = bus.m1_cyc_i;
    assign abort = 1'b0;
`endif

    // Marks an out-of-range TIMEOUT_CYCLES in the elaborated hierarchy.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_out_of_range
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            last_m1 <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            stall_cnt <= 8'd0;
            blocked   <= 2'b00;
`endif
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
            if (!bus.m0_cyc_i) blocked[0] <= 1'b0;
            if (!bus.m1_cyc_i) blocked[1] <= 1'b0;
            // s_cyc low covers IDLE and the cycle a grant is released or
            // handed over, so every new grant starts from zero.
            if (!s_cyc || bus.s_ack_i) begin
                stall_cnt <= 8'd0;
            end else if (stalled && stall_cnt != STALL_LIMIT) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
`endif
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last_m1)) begin
                        state   <= GRANT0;
                        last_m1 <= 1'b0;
                    end else if (req1) begin
                        state   <= GRANT1;
                        last_m1 <= 1'b1;
                    end
                end
                GRANT0: begin
                    if (abort) begin
                        state <= IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                        blocked[0] <= 1'b1;
`endif
                    end else if (!bus.m0_cyc_i) begin
                        // Hand over directly when the other master waits.
                        if (req1) begin
                            state   <= GRANT1;
                            last_m1 <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GRANT1: begin
                    if (abort) begin
                        state <= IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                        blocked[1] <= 1'b1;
`endif
                    end else if (!bus.m1_cyc_i) begin
                        if (req0) begin
                            state   <= GRANT0;
                            last_m1 <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shared-bus mux: follows the granted master, all zero in IDLE so a reset
    // drops cyc/stb within the same cycle.
    always_comb begin
        s_adr = '0;
        s_dat = '0;
        s_sel = '0;
        s_we  = 1'b0;
        s_cyc = 1'b0;
        s_stb = 1'b0;
        case (state)
            GRANT0: begin
                s_adr = bus.m0_adr_i;
                s_dat = bus.m0_dat_i;
                s_sel = bus.m0_sel_i;
                s_we  = bus.m0_we_i;
                s_cyc = bus.m0_cyc_i;
                s_stb = bus.m0_stb_i;
            end
            GRANT1: begin
                s_adr = bus.m1_adr_i;
                s_dat = bus.m1_dat_i;
                s_sel = bus.m1_sel_i;
                s_we  = bus.m1_we_i;
                s_cyc = bus.m1_cyc_i;
                s_stb = bus.m1_stb_i;
            end
            default: ;
        endcase
    end

    assign bus.s_adr_o = s_adr;
    assign bus.s_dat_o = s_dat;
    assign bus.s_sel_o = s_sel;
    assign bus.s_we_o  = s_we;
    assign bus.s_cyc_o = s_cyc;
    assign bus.s_stb_o = s_stb;

    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;
    assign bus.m0_ack_o = bus.s_ack_i & gnt0;
    assign bus.m1_ack_o = bus.s_ack_i & gnt1;
    assign bus.m0_err_o = abort & gnt0;
    assign bus.m1_err_o = abort & gnt1;
endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    localparam logic [AW-1:0] M0_ADR  = 32'h0000_1000;
    localparam logic [AW-1:0] M1_ADR  = 32'h0000_2000;
    localparam logic [DW-1:0] M0_WDAT = 16'h1111;
    localparam logic [DW-1:0] M1_WDAT = 16'h2222;
    localparam logic [SW-1:0] M0_SEL  = 2'b11;
    localparam logic [SW-1:0] M1_SEL  = 2'b10;
    localparam logic          M0_WE   = 1'b0;
    localparam logic          M1_WE   = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    wb_arbiter2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    wb_arbiter2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic          cyc;
        logic          stb;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        logic          we;
        logic          a0;
        logic          a1;
        logic          e0;
        logic          e1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } obs_t;

    // gnt: 0 = no grant expected, 1 = m0 on the bus, 2 = m1 on the bus
    typedef struct {
        logic          c0, s0, c1, s1, ack;
        logic [DW-1:0] sdat;
        int            gnt;
        logic          a0, a1;
    } vec_t;

    obs_t sb[$];
    vec_t vecs[16];

    function automatic vec_t mk(input logic c0, input logic s0, input logic c1, input logic s1,
                                input logic ack, input logic [DW-1:0] sdat, input int gnt,
                                input logic a0, input logic a1);
        vec_t v;
        v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack;
        v.sdat = sdat; v.gnt = gnt; v.a0 = a0; v.a1 = a1;
        return v;
    endfunction

    function automatic obs_t expect_of(input vec_t v);
        obs_t e;
        e = '0;
        if (v.gnt == 1) begin
            e.cyc = v.c0; e.stb = v.s0; e.adr = M0_ADR; e.dat = M0_WDAT; e.sel = M0_SEL; e.we = M0_WE;
        end else if (v.gnt == 2) begin
            e.cyc = v.c1; e.stb = v.s1; e.adr = M1_ADR; e.dat = M1_WDAT; e.sel = M1_SEL; e.we = M1_WE;
        end
        e.a0 = v.a0;
        e.a1 = v.a1;
        e.d0 = v.sdat;
        e.d1 = v.sdat;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.cyc = bus.s_cyc_o;  o.stb = bus.s_stb_o;  o.adr = bus.s_adr_o;
        o.dat = bus.s_dat_o;  o.sel = bus.s_sel_o;  o.we  = bus.s_we_o;
        o.a0  = bus.m0_ack_o; o.a1  = bus.m1_ack_o;
        o.e0  = bus.m0_err_o; o.e1  = bus.m1_err_o;
        o.d0  = bus.m0_dat_o; o.d1  = bus.m1_dat_o;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.m0_cyc_i = v.c0;
        bus.m0_stb_i = v.s0;
        bus.m1_cyc_i = v.c1;
        bus.m1_stb_i = v.s1;
        bus.s_ack_i  = v.ack;
        bus.s_dat_i  = v.sdat;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t exp;
        int   lat;
        int   n;
        int   bad;

        bus.m0_adr_i = M0_ADR;  bus.m0_dat_i = M0_WDAT; bus.m0_sel_i = M0_SEL; bus.m0_we_i = M0_WE;
        bus.m1_adr_i = M1_ADR;  bus.m1_dat_i = M1_WDAT; bus.m1_sel_i = M1_SEL; bus.m1_we_i = M1_WE;
        drive(mk(1, 1, 0, 0, 1, 16'h1234, 0, 0, 0));

        // During reset: everything 0 except read data, even with a request and ack.
        @(negedge clk);
        exp = '0; exp.d0 = 16'h1234; exp.d1 = 16'h1234;
        check_obs("reset_hold", sample(), exp);
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 16'h1234, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk);
        check_obs("reset_after", sample(), exp);

        // {m0 cyc, stb, m1 cyc, stb, s_ack, s_dat, expected grant, m0_ack, m1_ack}
        vecs[0]  = mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 1, 0, 16'h0000, 0, 0, 0);  // tie after reset
        vecs[2]  = mk(1, 1, 1, 1, 1, 16'h5A5A, 1, 1, 0);  // m0 wins the first tie
        vecs[3]  = mk(0, 0, 1, 1, 0, 16'h0000, 1, 0, 0);  // m0 releases
        vecs[4]  = mk(0, 0, 1, 1, 1, 16'h6B6B, 2, 0, 1);  // m1 with no IDLE bubble
        vecs[5]  = mk(1, 1, 1, 0, 0, 16'h0000, 2, 0, 0);  // m0 requests during m1 lock
        vecs[6]  = mk(1, 1, 1, 1, 1, 16'h7C7C, 2, 0, 1);
        vecs[7]  = mk(1, 1, 1, 1, 1, 16'h7D7D, 2, 0, 1);
        vecs[8]  = mk(1, 1, 0, 0, 0, 16'h0000, 2, 0, 0);  // m1 releases
        vecs[9]  = mk(1, 1, 0, 0, 1, 16'h8E8E, 1, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 16'h9F9F, 0, 0, 0);  // ack in IDLE is ignored
        vecs[12] = mk(1, 1, 0, 0, 0, 16'h0000, 0, 0, 0);  // m0 single read of 0x1000
        vecs[13] = mk(1, 1, 0, 0, 1, 16'hABCD, 1, 1, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            sb.push_back(expect_of(vecs[i]));
            @(negedge clk);
            if (sb.size() == 0) begin
                check_val($sformatf("vec%0d_scoreboard", i), 0, 1);
            end else begin
                check_obs($sformatf("vec%0d", i), sample(), sb.pop_front());
            end
        end

        // Reset in the middle of a granted strobe.
        @(posedge clk); #1;
        drive(mk(1, 1, 0, 0, 0, 16'h4321, 0, 0, 0));
        lat = -1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.s_cyc_o) begin
                lat = k;
                break;
            end
        end
        check_val("rst_pre_grant_latency", lat, 1);
        bus.s_ack_i = 1'b1;
        rst = 1'b1;
        #1;
        exp = '0; exp.d0 = 16'h4321; exp.d1 = 16'h4321;
        check_obs("rst_mid_cycle", sample(), exp);
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 16'h4321, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk);
        check_obs("rst_released", sample(), exp);
        @(posedge clk); #1;
        drive(mk(1, 1, 0, 0, 0, 16'h4321, 0, 0, 0));
        @(negedge clk);
        check_val("rst_state_idle", bus.s_cyc_o, 0);
        @(negedge clk);
        check_val("rst_regrant", bus.s_cyc_o, 1);
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0));

        // Stalled slave: both masters request right after a fresh reset.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(mk(1, 1, 1, 1, 0, 16'h0000, 0, 0, 0));
`ifdef WB_ARB_TIMEOUT_EN
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.m0_err_o) begin
                n = k;
                break;
            end
        end
        // IDLE cycle, grant cycle, TO stalled strobes, then the err cycle.
        check_val("to_err_cycle", n, TO + 2);
        @(negedge clk);
        exp = '0;
        check_obs("to_err_single_idle", sample(), exp);
        @(negedge clk);
        check_obs("to_m1_granted", sample(), expect_of(mk(1, 1, 1, 1, 0, 16'h0000, 2, 0, 0)));
        @(posedge clk); #1;
        drive(mk(1, 1, 0, 0, 0, 16'h0000, 0, 0, 0));
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.s_cyc_o || bus.m0_err_o) bad++;
        end
        check_val("to_m0_blocked", bad, 0);
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(1, 1, 0, 0, 0, 16'h0000, 0, 0, 0));
        @(negedge clk);
        check_val("to_regrant_idle", bus.s_cyc_o, 0);
        @(negedge clk);
        check_obs("to_m0_regranted", sample(), expect_of(mk(1, 1, 0, 0, 0, 16'h0000, 1, 0, 0)));
`else
        @(negedge clk);
        check_obs("stall_grant_m0", sample(), expect_of(mk(1, 1, 1, 1, 0, 16'h0000, 0, 0, 0)));
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!bus.s_cyc_o || bus.s_adr_o !== M0_ADR || bus.m0_err_o || bus.m1_err_o) bad++;
        end
        check_val("stall_hold_1000", bad, 0);
`endif
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
Parameters
REQ-001 The block SHALL take parameter DATA_WIDTH, default 16: width of the data bus.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 32: width of the address bus.
REQ-003 The block SHALL take parameter TIMEOUT_CYCLES, default 255, range 2..255: number of stalled strobe cycles tolerated before abort.

Ports (mN = m0 and m1; m0 is the CPU core, m1 is the gdb target)
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have ports mN_dat_i, input, DATA_WIDTH: master write data.
REQ-007 The block SHALL have ports mN_dat_o, output, DATA_WIDTH: read data, equal to s_dat_i for both masters.
REQ-008 The block SHALL have ports mN_adr_i, input, ADDR_WIDTH: master address.
REQ-009 The block SHALL have ports mN_sel_i, input, DATA_WIDTH/8: master byte selects.
REQ-010 The block SHALL have ports mN_we_i, mN_cyc_i and mN_stb_i, input, 1 bit each: master write enable, cycle and strobe.
REQ-011 The block SHALL have ports mN_ack_o, output, 1 bit: master acknowledge.
REQ-012 The block SHALL have ports mN_err_o, output, 1 bit: timeout error pulse.
REQ-013 The block SHALL have ports s_dat_o (DATA_WIDTH), s_adr_o (ADDR_WIDTH), s_sel_o (DATA_WIDTH/8), and s_we_o, s_cyc_o, s_stb_o (1 bit each), all outputs: the shared bus toward the bus interconnect.
REQ-014 The block SHALL have port s_dat_i, input, DATA_WIDTH: shared read data.
REQ-015 The block SHALL have port s_ack_i, input, 1 bit: shared acknowledge.

Function
REQ-016 The block SHALL implement states IDLE, GRANT0 and GRANT1, held in registers.
REQ-017 In IDLE with exactly one mN_cyc_i high, the block SHALL enter GRANTn on the next edge.
REQ-018 In IDLE with both mN_cyc_i high, the block SHALL grant the master not served last (round-robin).
REQ-019 The block SHALL update the last-served register on every grant.
REQ-020 Grant latency SHALL be one cycle from mN_cyc_i high in IDLE to s_cyc_o high.
REQ-021 In GRANTn, the block SHALL drive s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o combinationally from master n.
REQ-022 In IDLE, s_cyc_o and s_stb_o SHALL be 0, and s_adr_o, s_dat_o, s_sel_o and s_we_o SHALL be 0.
REQ-023 mN_ack_o SHALL equal s_ack_i AND (state == GRANTn), so the non-granted master never sees ack.
REQ-024 A grant SHALL be held for the whole cycle, across multiple strobes, while mN_cyc_i stays high (bus lock).
REQ-025 When the granted master drops cyc_i and the other master's cyc_i is high, the block SHALL go directly to the other GRANT state with no IDLE bubble.
REQ-026 When the granted master drops cyc_i and the other master's cyc_i is low, the block SHALL go to IDLE.
REQ-027 An s_ack_i arriving in IDLE SHALL be ignored.

Reset
REQ-028 On rst_i high, the block SHALL asynchronously force state to IDLE, set last-served to m1 (so m0 wins the first tie), clear the timeout counter and clear the blocked flags.
REQ-029 During and directly after reset, all outputs SHALL be 0 except mN_dat_o, which follows s_dat_i.
REQ-030 A reset asserted mid-cycle SHALL drop s_cyc_o and s_stb_o within the same cycle, with no ack or err delivered.

Configuration
REQ-031 When macro WB_ARB_TIMEOUT_EN is defined, the block SHALL include an 8-bit stall counter.
REQ-032 With WB_ARB_TIMEOUT_EN defined, the counter SHALL clear on grant entry and on s_ack_i, and SHALL increment each GRANTn cycle with s_stb_o=1 and s_ack_i=0.
REQ-033 With WB_ARB_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES the block SHALL pulse mN_err_o for one cycle, return to IDLE, and set blocked[n].
REQ-034 With WB_ARB_TIMEOUT_EN defined, a blocked master SHALL not be granted again until its cyc_i has been sampled low, which clears blocked[n].
REQ-035 An s_ack_i that coincides with the counter reaching the limit SHALL win: ack is delivered and no err is raised.
REQ-036 Without WB_ARB_TIMEOUT_EN, the block SHALL contain no counter and no blocked flags, mN_err_o SHALL be tied 0, and a stalled cycle SHALL hold the bus indefinitely.

Verification
REQ-037 The bench SHALL cover: m0 single read of adr 0x00001000, slave acks on cycle 2 -> s_cyc_o high 1 cycle after m0_cyc_i, m0_ack_o=1 and m0_dat_o=s_dat_i=0xABCD, m1_ack_o=0.
REQ-038 The bench SHALL cover: m0 and m1 raise cyc_i in the same cycle after reset -> m0 granted first; after m0 drops cyc, m1 is granted on the next edge with no IDLE cycle.
REQ-039 The bench SHALL cover: m1 holds cyc_i for 3 strobes while m0 requests -> m0 stays ungranted until m1 releases, and m0 receives no ack.
REQ-040 The bench SHALL cover: rst_i pulsed while GRANT0 with stb high -> s_cyc_o and s_stb_o drop in the same cycle, state is IDLE, and there is no ack or err.
REQ-041 The bench SHALL cover: with WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> m0_err_o pulses for exactly 1 cycle, the bus goes IDLE, m1 (requesting) is granted next, and m0 is not regranted until its cyc_i goes low.
REQ-042 The bench SHALL cover: the same stall without WB_ARB_TIMEOUT_EN -> no err, and s_cyc_o stays high for 1000 cycles.
